// File: rtl/ray_aabb_pkg.sv
// Shared types and constants for the Ray_AABB_11_12 slab reduction stage.
package ray_aabb_pkg;

  localparam int unsigned WE    = 11;
  localparam int unsigned WF    = 12;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned W     = WE + WF + 3;

  // Bit offsets of the FloPoCo word {exn[1:0], sign, exp, frac}
  localparam int unsigned FRAC_LSB = 0;
  localparam int unsigned EXP_LSB  = WF;
  localparam int unsigned SIGN_BIT = WE + WF;
  localparam int unsigned EXN_LSB  = WE + WF + 1;

  typedef logic [1:0] exn_t;
  localparam exn_t EXN_ZERO = 2'b00;
  localparam exn_t EXN_NORM = 2'b01;
  localparam exn_t EXN_INF  = 2'b10;
  localparam exn_t EXN_NAN  = 2'b11;

  typedef struct packed {
    exn_t          exn;
    logic          sign;
    logic [WE-1:0] exp;
    logic [WF-1:0] frac;
  } fp_t;

  localparam fp_t FP_ZERO = '0;

  // Accepted ray payload
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    fp_t              nx;
    fp_t              ny;
    fp_t              nz;
    fp_t              fx;
    fp_t              fy;
    fp_t              fz;
  } ray_in_t;

  // Result payload
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    fp_t              tmin;
    fp_t              tmax;
    logic             hit;
    logic             nan;
  } ray_out_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XY   = 3'd1,
    S_Z    = 3'd2,
    S_HIT  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/ray_slab_reduce_if.sv
// Input/result handshake bundle of the slab reduction stage.
interface ray_slab_reduce_if;
  import ray_aabb_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  fp_t              tnear_x;
  fp_t              tnear_y;
  fp_t              tnear_z;
  fp_t              tfar_x;
  fp_t              tfar_y;
  fp_t              tfar_z;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  fp_t              out_tmin;
  fp_t              out_tmax;
  logic             out_hit;
  logic             out_nan;

  modport master (
    output in_valid, in_tag, tnear_x, tnear_y, tnear_z, tfar_x, tfar_y, tfar_z, out_ready,
    input  in_ready, out_valid, out_tag, out_tmin, out_tmax, out_hit, out_nan
  );

  modport slave (
    input  in_valid, in_tag, tnear_x, tnear_y, tnear_z, tfar_x, tfar_y, tfar_z, out_ready,
    output in_ready, out_valid, out_tag, out_tmin, out_tmax, out_hit, out_nan
  );

endinterface

// File: rtl/fp_gt_cmp.sv
// Combinational a > b on FloPoCo words; any NaN operand gives false.
module fp_gt_cmp
  import ray_aabb_pkg::*;
(
  input  fp_t  i_a,
  input  fp_t  i_b,
  output logic o_gt_c
);

  // Total-order rank: -inf < -normal < +-0 < +normal < +inf
  localparam logic [2:0] CLS_NINF = 3'd0;
  localparam logic [2:0] CLS_NEG  = 3'd1;
  localparam logic [2:0] CLS_ZERO = 3'd2;
  localparam logic [2:0] CLS_POS  = 3'd3;
  localparam logic [2:0] CLS_PINF = 3'd4;

  logic [2:0]       w_cls_a;
  logic [2:0]       w_cls_b;
  logic [WE+WF-1:0] w_mag_a;
  logic [WE+WF-1:0] w_mag_b;
  logic             w_any_nan;

  function automatic logic [2:0] fp_class(fp_t x);
    logic [2:0] c;
    c = CLS_ZERO;
    case (x.exn)
      EXN_NORM: c = x.sign ? CLS_NEG : CLS_POS;
      EXN_INF:  c = x.sign ? CLS_NINF : CLS_PINF;
      default:  c = CLS_ZERO;
    endcase
    return c;
  endfunction

  assign w_cls_a   = fp_class(i_a);
  assign w_cls_b   = fp_class(i_b);
  assign w_mag_a   = {i_a.exp, i_a.frac};
  assign w_mag_b   = {i_b.exp, i_b.frac};
  assign w_any_nan = (i_a.exn == EXN_NAN) || (i_b.exn == EXN_NAN);

  // Rank first, magnitude only between normals of the same sign
  always_comb begin
    o_gt_c = 1'b0;
    if (w_any_nan) begin
      o_gt_c = 1'b0;
    end else if (w_cls_a != w_cls_b) begin
      o_gt_c = (w_cls_a > w_cls_b);
    end else if (w_cls_a == CLS_POS) begin
      o_gt_c = (w_mag_a > w_mag_b);
    end else if (w_cls_a == CLS_NEG) begin
      o_gt_c = (w_mag_a < w_mag_b);
    end
  end

endmodule

// File: rtl/ray_slab_reduce.sv
// Iterative reduction of per-axis slab distances to [tmin, tmax] and a hit flag.
module ray_slab_reduce
  import ray_aabb_pkg::*;
(
  input logic              clk,
  input logic              rst,
  ray_slab_reduce_if.slave io_bus
);

  state_t   r_state, w_state_nxt;
  logic     r_in_ready, w_in_ready_nxt;
  logic     r_out_valid, w_out_valid_nxt;
  logic     r_nan_acc, w_nan_acc_nxt;
  ray_in_t  r_in, w_in_nxt;
  ray_out_t r_out, w_out_nxt;
  fp_t      r_tmin, w_tmin_nxt;
  fp_t      r_tmax, w_tmax_nxt;

  ray_in_t  w_in_c;
  logic     w_nan_in;
  fp_t      w_near_a, w_near_b, w_far_a, w_far_b;
  logic     w_near_gt, w_far_gt;

  assign w_in_c = '{tag: io_bus.in_tag,
                    nx:  io_bus.tnear_x, ny: io_bus.tnear_y, nz: io_bus.tnear_z,
                    fx:  io_bus.tfar_x,  fy: io_bus.tfar_y,  fz: io_bus.tfar_z};

  assign w_nan_in = (io_bus.tnear_x.exn == EXN_NAN) || (io_bus.tnear_y.exn == EXN_NAN) ||
                    (io_bus.tnear_z.exn == EXN_NAN) || (io_bus.tfar_x.exn  == EXN_NAN) ||
                    (io_bus.tfar_y.exn  == EXN_NAN) || (io_bus.tfar_z.exn  == EXN_NAN);

  // Operand steering for the two shared comparators
  always_comb begin
    w_near_a = r_in.ny;
    w_near_b = r_in.nx;
    w_far_a  = r_in.fx;
    w_far_b  = r_in.fy;
    case (r_state)
      S_Z: begin
        w_near_a = r_in.nz;
        w_near_b = r_tmin;
        w_far_a  = r_tmax;
        w_far_b  = r_in.fz;
      end
      S_HIT: begin
        w_near_a = r_tmin;
        w_near_b = r_tmax;
        w_far_a  = FP_ZERO;
        w_far_b  = r_tmax;
      end
      default: ;
    endcase
  end

  fp_gt_cmp u_cmp_near (.i_a(w_near_a), .i_b(w_near_b), .o_gt_c(w_near_gt));
  fp_gt_cmp u_cmp_far  (.i_a(w_far_a),  .i_b(w_far_b),  .o_gt_c(w_far_gt));

  // Next-state and datapath updates; ties keep the earlier axis
  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_nan_acc_nxt   = r_nan_acc;
    w_in_nxt        = r_in;
    w_out_nxt       = r_out;
    w_tmin_nxt      = r_tmin;
    w_tmax_nxt      = r_tmax;
    case (r_state)
      S_IDLE: begin
        if (io_bus.in_valid && r_in_ready) begin
          w_in_nxt       = w_in_c;
          w_nan_acc_nxt  = w_nan_in;
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = S_XY;
        end
      end
      S_XY: begin
        w_tmin_nxt  = w_near_gt ? r_in.ny : r_in.nx;
        w_tmax_nxt  = w_far_gt ? r_in.fy : r_in.fx;
        w_state_nxt = S_Z;
      end
      S_Z: begin
        w_tmin_nxt  = w_near_gt ? r_in.nz : r_tmin;
        w_tmax_nxt  = w_far_gt ? r_in.fz : r_tmax;
        w_state_nxt = S_HIT;
      end
      S_HIT: begin
        w_out_nxt = '{tag:  r_in.tag,
                      tmin: r_tmin,
                      tmax: r_tmax,
                      hit:  !r_nan_acc && !w_near_gt && !w_far_gt,
                      nan:  r_nan_acc};
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_OUT;
      end
      S_OUT: begin
        if (io_bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_in_ready_nxt  = 1'b1;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_nan_acc   <= 1'b0;
      r_in        <= '0;
      r_out       <= '0;
      r_tmin      <= '0;
      r_tmax      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_nan_acc   <= w_nan_acc_nxt;
      r_in        <= w_in_nxt;
      r_out       <= w_out_nxt;
      r_tmin      <= w_tmin_nxt;
      r_tmax      <= w_tmax_nxt;
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_tag   = r_out.tag;
  assign io_bus.out_tmin  = r_out.tmin;
  assign io_bus.out_tmax  = r_out.tmax;
  assign io_bus.out_hit   = r_out.hit;
  assign io_bus.out_nan   = r_out.nan;

endmodule

// File: tb/tb_ray_slab_reduce.sv
// Directed bench for ray_slab_reduce: vector table plus handshake/reset sequences.
module tb_ray_slab_reduce;
  import ray_aabb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ray_slab_reduce_if bus ();

  ray_slab_reduce dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     nx, ny, nz, fx, fy, fz;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     tmin, tmax;
    logic             hit;
    logic             nan;
    logic             chk_t;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_tag  = v.tag;
    bus.tnear_x = v.nx;
    bus.tnear_y = v.ny;
    bus.tnear_z = v.nz;
    bus.tfar_x  = v.fx;
    bus.tfar_y  = v.fy;
    bus.tfar_z  = v.fz;
  endtask

  // Called at a negedge; sends one ray, checks latency and result, consumes it
  task automatic run_vec(input vec_t v, input string nm);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({nm, "_busy"}, 32'(bus.in_ready), 32'd0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, 32'(n), 32'd3);
    check({nm, "_tag"}, 32'(bus.out_tag), 32'(v.tag));
    if (v.chk_t) begin
      check({nm, "_tmin"}, 32'(bus.out_tmin), 32'(v.tmin));
      check({nm, "_tmax"}, 32'(bus.out_tmax), 32'(v.tmax));
    end
    check({nm, "_hit"}, 32'(bus.out_hit), 32'(v.hit));
    check({nm, "_nan"}, 32'(bus.out_nan), 32'(v.nan));
    @(negedge clk);
    check({nm, "_drop"}, 32'(bus.out_valid), 32'd0);
    check({nm, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int   n;
    logic seen;
    checks   = 0;
    failures = 0;

    //           nx          ny          nz          fx          fy          fz       tag    tmin        tmax     hit nan chk
    vecs[0] = '{26'h13FE000, 26'h13FF000, 26'h1BFF000, 26'h1400800, 26'h1400000, 26'h1400800, 8'h11, 26'h13FF000, 26'h1400000, 1'b1, 1'b0, 1'b1}; // hit
    vecs[1] = '{26'h1400000, 26'h13FE000, 26'h13FE000, 26'h1400800, 26'h13FF000, 26'h1400800, 8'h22, 26'h1400000, 26'h13FF000, 1'b0, 1'b0, 1'b1}; // miss
    vecs[2] = '{26'h1BFF000, 26'h1BFF000, 26'h1BFF000, 26'h1BFF000, 26'h1BFF000, 26'h1BFF000, 8'h33, 26'h1BFF000, 26'h1BFF000, 1'b0, 1'b0, 1'b1}; // tmax < 0
    vecs[3] = '{26'h13FF000, 26'h0000000, 26'h0000000, 26'h13FF000, 26'h2000000, 26'h2000000, 8'h44, 26'h13FF000, 26'h13FF000, 1'b1, 1'b0, 1'b1}; // tmin == tmax
    vecs[4] = '{26'h0000000, 26'h0800000, 26'h1BFF000, 26'h13FF000, 26'h13FF000, 26'h13FF000, 8'h55, 26'h0000000, 26'h13FF000, 1'b1, 1'b0, 1'b1}; // +0 x vs -0 y
    vecs[5] = '{26'h0800000, 26'h0000000, 26'h1BFF000, 26'h13FF000, 26'h13FF000, 26'h13FF000, 8'h66, 26'h0800000, 26'h13FF000, 1'b1, 1'b0, 1'b1}; // -0 x vs +0 y
    vecs[6] = '{26'h13FE000, 26'h13FF000, 26'h1BFF000, 26'h1400800, 26'h3000000, 26'h1400800, 8'h77, 26'h0000000, 26'h0000000, 1'b0, 1'b1, 1'b0}; // NaN
    vecs[7] = '{26'h1BFF000, 26'h1BFF000, 26'h1BFF000, 26'h0800000, 26'h13FF000, 26'h13FF000, 8'h88, 26'h1BFF000, 26'h0800000, 1'b1, 1'b0, 1'b1}; // tmax == -0
    vecs[8] = '{26'h2800000, 26'h13FE000, 26'h2800000, 26'h2000000, 26'h2000000, 26'h1400000, 8'h99, 26'h13FE000, 26'h1400000, 1'b1, 1'b0, 1'b1}; // infinities
    vecs[9] = '{26'h1BFF000, 26'h1C00000, 26'h1BFE000, 26'h13FE000, 26'h1400000, 26'h13FF000, 8'hAA, 26'h1BFE000, 26'h13FE000, 1'b1, 1'b0, 1'b1}; // negative order

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_hit",   32'(bus.out_hit),   32'd0);
    check("rst_out_nan",   32'(bus.out_nan),   32'd0);
    check("rst_out_tag",   32'(bus.out_tag),   32'd0);
    check("rst_out_tmin",  32'(bus.out_tmin),  32'd0);
    check("rst_out_tmax",  32'(bus.out_tmax),  32'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Back-pressure: result must hold, pulsed in_valid must be dropped
    drive(vecs[1]);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("hold_latency", 32'(n), 32'd3);
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = (k == 1);
      bus.in_tag   = 8'hEE;
      @(negedge clk);
      check($sformatf("hold%0d_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("hold%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
      check($sformatf("hold%0d_tag", k), 32'(bus.out_tag), 32'h22);
      check($sformatf("hold%0d_tmin", k), 32'(bus.out_tmin), 32'h1400000);
      check($sformatf("hold%0d_tmax", k), 32'(bus.out_tmax), 32'h13FF000);
      check($sformatf("hold%0d_hit", k), 32'(bus.out_hit), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", 32'(bus.out_valid), 32'd0);
    check("hold_release_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("hold_no_queued_ray", 32'(seen), 32'd0);

    // Reset while the ray sits in S_Z discards it
    drive(vecs[1]);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("midrst_discarded", 32'(seen), 32'd0);
    run_vec(vecs[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
